// File: rtl/neuron_pkg.sv
// Shared definitions for the sequential neuron: activation mode codes, FSM states
// and the accumulator width rule.
package neuron_pkg;

    localparam logic [1:0] MODE_LINEAR = 2'b00;
    localparam logic [1:0] MODE_RELU   = 2'b01;
    localparam logic [1:0] MODE_STEP   = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        ACT  = 2'd2
    } state_t;

    // Product width doubles the operand width; the extra bits absorb the
    // sum of NUM_IN products plus the bias without wrapping.
    function automatic int acc_width(input int w, input int n);
        return 2 * w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/neuron_act.sv
// Combinational activation stage: saturates the wide accumulator to W bits and
// applies the selected linear / ReLU / step function.
module neuron_act
    import neuron_pkg::*;
#(
    parameter int W     = 32,
    parameter int ACC_W = 67
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [1:0]       mode,
    output logic        [W-1:0]     result
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    logic [W-1:0] sat;
    logic         negative;

    assign negative = acc[ACC_W-1];

    always_comb begin
        if (acc > MAX_V) begin
            sat = MAX_V[W-1:0];
        end else if (acc < MIN_V) begin
            sat = MIN_V[W-1:0];
        end else begin
            sat = acc[W-1:0];
        end
    end

    // Mode 11 is unassigned and falls through to linear.
    always_comb begin
        result = sat;
        case (mode)
            MODE_RELU: result = negative ? '0 : sat;
            MODE_STEP: result = negative ? '0 : W'(1);
            default:   result = sat;
        endcase
    end

endmodule

// File: rtl/neuron_seq.sv
// Sequential neuron: captures NUM_IN input/weight pairs, accumulates one product
// per cycle onto the bias, then registers the activated result with a done pulse.
module neuron_seq
    import neuron_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_IN*W-1:0] x,
    input  logic [NUM_IN*W-1:0] w,
    input  logic [W-1:0]        bias,
    input  logic [1:0]          mode,
    output logic [W-1:0]        out,
    output logic                done,
    output logic                busy
);

    localparam int ACC_W = acc_width(W, NUM_IN);
    localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

    state_t                    state;
    logic signed [ACC_W-1:0]   acc;
    logic        [IDX_W-1:0]   idx;
    logic        [NUM_IN*W-1:0] x_q;
    logic        [NUM_IN*W-1:0] w_q;
    logic        [1:0]         mode_q;
    logic signed [2*W-1:0]     prod;
    logic        [W-1:0]       act_result;

    assign prod = $signed(x_q[idx*W +: W]) * $signed(w_q[idx*W +: W]);
    assign busy = (state != IDLE);

    neuron_act #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_act (
        .acc    (acc),
        .mode   (mode_q),
        .result (act_result)
    );

    // Operands are latched on acceptance so later input changes cannot disturb
    // an evaluation in flight; start is only looked at in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            idx    <= '0;
            out    <= '0;
            done   <= 1'b0;
            x_q    <= '0;
            w_q    <= '0;
            mode_q <= MODE_LINEAR;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_q    <= x;
                        w_q    <= w;
                        mode_q <= mode;
                        acc    <= {{(ACC_W-W){bias[W-1]}}, bias};
                        idx    <= '0;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + {{(ACC_W-2*W){prod[2*W-1]}}, prod};
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= ACT;
                    end
                end
                ACT: begin
                    out   <= act_result;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_seq.sv
// Self-checking bench for neuron_seq: directed vector table, hand-built
// multi-cycle sequences and randomized evaluations against a wide-integer model.
module tb_neuron_seq;

    localparam int NUM_IN = 4;
    localparam int W      = 32;
    localparam logic signed [127:0] MAXV = (128'sd1 <<< (W-1)) - 128'sd1;
    localparam logic signed [127:0] MINV = -(128'sd1 <<< (W-1));

    logic                clk;
    logic                rst;
    logic                start;
    logic [NUM_IN*W-1:0] x;
    logic [NUM_IN*W-1:0] w;
    logic [W-1:0]        bias;
    logic [1:0]          mode;
    logic [W-1:0]        out;
    logic                done;
    logic                busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NUM_IN*W-1:0] xv;
        logic [NUM_IN*W-1:0] wv;
        logic [W-1:0]        b;
        logic [1:0]          m;
        logic [W-1:0]        expected;
    } vec_t;

    vec_t vecs[12];

    neuron_seq #(
        .NUM_IN (NUM_IN),
        .W      (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .w     (w),
        .bias  (bias),
        .mode  (mode),
        .out   (out),
        .done  (done),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NUM_IN*W-1:0] pack4(input logic [W-1:0] a, input logic [W-1:0] b,
                                                   input logic [W-1:0] c, input logic [W-1:0] d);
        return {d, c, b, a};
    endfunction

    // Reference: exact dot product in 128-bit arithmetic, then clamp and activate.
    function automatic logic [W-1:0] modelNeuron(input logic [NUM_IN*W-1:0] xv,
                                                 input logic [NUM_IN*W-1:0] wv,
                                                 input logic [W-1:0] b, input logic [1:0] m);
        logic signed [127:0] sum;
        logic signed [127:0] satv;
        logic signed [W-1:0] xe;
        logic signed [W-1:0] we;
        logic signed [W-1:0] be;
        be  = b;
        sum = be;
        for (int i = 0; i < NUM_IN; i++) begin
            xe  = xv[i*W +: W];
            we  = wv[i*W +: W];
            sum = sum + xe * we;
        end
        if (sum > MAXV) satv = MAXV;
        else if (sum < MINV) satv = MINV;
        else satv = sum;
        case (m)
            2'b01:   return (sum < 0) ? '0 : satv[W-1:0];
            2'b10:   return (sum >= 0) ? W'(1) : '0;
            default: return satv[W-1:0];
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full evaluation: start for a single cycle, scramble the inputs right
    // after capture, and check busy/done on every cycle up to the done pulse.
    task automatic applyStimulus(input string name, input logic [NUM_IN*W-1:0] xv,
                                 input logic [NUM_IN*W-1:0] wv, input logic [W-1:0] b,
                                 input logic [1:0] m, input logic [W-1:0] expected);
        @(negedge clk);
        x = xv; w = wv; bias = b; mode = m; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        x     = ~xv;
        w     = {$urandom, $urandom, $urandom, $urandom};
        bias  = $urandom;
        mode  = m ^ 2'b01;
        for (int k = 1; k <= NUM_IN + 1; k++) begin
            checkOutput($sformatf("%s busy e%0d", name, k), W'(busy), W'(1));
            checkOutput($sformatf("%s done e%0d", name, k), W'(done), W'(0));
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput({name, " done"}, W'(done), W'(1));
        checkOutput({name, " idle"}, W'(busy), W'(0));
        checkOutput({name, " out"}, out, expected);
        @(posedge clk);
        @(negedge clk);
        checkOutput({name, " done1cyc"}, W'(done), W'(0));
        checkOutput({name, " hold"}, out, expected);
    endtask

    initial begin
        int firstDone;
        int secondDone;
        int doneCount;
        logic [W-1:0] outAtDone;
        logic [NUM_IN*W-1:0] rx;
        logic [NUM_IN*W-1:0] rw;
        logic [W-1:0] rb;
        logic [1:0] rm;
        logic [W-1:0] v;

        rst = 1'b1; start = 1'b0; x = '0; w = '0; bias = '0; mode = '0;

        vecs[0]  = '{pack4(1,2,3,4), pack4(1,1,1,1), 32'd0, 2'b00, 32'd10};
        vecs[1]  = '{pack4(1,2,3,4), {4{32'hFFFFFFFF}}, 32'd0, 2'b00, 32'hFFFFFFF6};
        vecs[2]  = '{pack4(1,2,3,4), {4{32'hFFFFFFFF}}, 32'd0, 2'b01, 32'd0};
        vecs[3]  = '{pack4(1,2,3,4), {4{32'hFFFFFFFF}}, 32'd0, 2'b10, 32'd0};
        vecs[4]  = '{pack4(1,2,3,4), pack4(1,1,1,1), 32'd0, 2'b01, 32'd10};
        vecs[5]  = '{pack4(1,2,3,4), pack4(1,1,1,1), 32'd0, 2'b10, 32'd1};
        vecs[6]  = '{pack4(1,2,3,4), {4{32'hFFFFFFFF}}, 32'd0, 2'b11, 32'hFFFFFFF6};
        vecs[7]  = '{pack4(32'h7FFFFFFF,0,0,0), pack4(32'h7FFFFFFF,0,0,0), 32'd0, 2'b00, 32'h7FFFFFFF};
        vecs[8]  = '{pack4(32'h7FFFFFFF,0,0,0), pack4(32'h80000001,0,0,0), 32'd0, 2'b00, 32'h80000000};
        vecs[9]  = '{pack4(2,0,0,0), pack4(3,0,0,0), 32'hFFFFFFFA, 2'b10, 32'd1};
        vecs[10] = '{pack4(2,0,0,0), pack4(3,0,0,0), 32'hFFFFFFF9, 2'b10, 32'd0};
        vecs[11] = '{{4{32'h80000000}}, {4{32'h80000000}}, 32'h7FFFFFFF, 2'b01, 32'h7FFFFFFF};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset out", out, '0);
        checkOutput("reset done", W'(done), W'(0));
        checkOutput("reset busy", W'(busy), W'(0));

        foreach (vecs[i]) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].xv, vecs[i].wv, vecs[i].b, vecs[i].m, vecs[i].expected);
        end

        // Start at edge 0, a second pulse at edge 2 (busy, must be dropped),
        // then a third start in the done cycle that must run back-to-back.
        doReset();
        x = pack4(1,2,3,4); w = pack4(1,1,1,1); bias = '0; mode = 2'b00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        x = pack4(1,2,3,4); w = {4{32'hFFFFFFFF}}; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        firstDone = -1;
        for (int k = 3; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done && firstDone < 0) begin
                firstDone = k;
                break;
            end
        end
        checkOutput("b2b first done edge", W'(firstDone), W'(5));
        checkOutput("b2b first out", out, 32'd10);
        x = pack4(1,2,3,4); w = pack4(2,2,2,2); start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        doneCount = 0; secondDone = -1; outAtDone = '0;
        for (int k = 7; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                doneCount++;
                if (secondDone < 0) begin
                    secondDone = k;
                    outAtDone  = out;
                end
            end
        end
        checkOutput("b2b done count", W'(doneCount), W'(1));
        // Start sampled at edge 6, so its done follows edge 6+NUM_IN+1.
        checkOutput("b2b second done edge", W'(secondDone), W'(11));
        checkOutput("b2b second out", outAtDone, 32'd20);

        // Abort mid-evaluation with reset at edge 3.
        @(negedge clk);
        x = pack4(1,2,3,4); w = pack4(1,1,1,1); bias = '0; mode = 2'b00; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort out", out, '0);
        checkOutput("abort busy", W'(busy), W'(0));
        checkOutput("abort done", W'(done), W'(0));
        doneCount = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("abort no done", W'(doneCount), W'(0));
        applyStimulus("after abort", pack4(5,6,7,8), pack4(1,1,1,1), 32'd3, 2'b00, 32'd29);

        for (int n = 0; n < 150; n++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (n % 3 == 0) begin
                    rx[i*W +: W] = $urandom;
                    rw[i*W +: W] = $urandom;
                end else begin
                    v = $urandom_range(0, 200);
                    rx[i*W +: W] = v - 32'd100;
                    v = $urandom_range(0, 200);
                    rw[i*W +: W] = v - 32'd100;
                end
            end
            rb = (n % 2 == 0) ? W'($urandom) : W'($urandom_range(0, 400)) - 32'd200;
            rm = 2'($urandom_range(0, 3));
            applyStimulus($sformatf("rand%0d", n), rx, rw, rb, rm, modelNeuron(rx, rw, rb, rm));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
